// File: rtl/id_stage_pipe.sv
// Instruction-decode stage: register file with write-back bypass, immediate
// extension by opcode, and an ID/EX output register with valid/ready
// handshake, flush, stall and automatic load-use bubble insertion.
module id_stage_pipe #(
   parameter int          DATA_W   = 32,
   parameter int          NREGS    = 32,
   parameter bit          ZERO_REG = 1'b1,
   parameter logic [5:0]  LOAD_OPC = 6'h23,
   localparam int         AW       = (NREGS > 1) ? $clog2(NREGS) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       instruction,
   input  logic [31:0]       pc_in,
   input  logic              flush,
   input  logic              wb_en,
   input  logic [AW-1:0]     wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [5:0]        out_opcode,
   output logic [4:0]        out_rs,
   output logic [4:0]        out_rt,
   output logic [4:0]        out_rd,
   output logic [DATA_W-1:0] out_rs_data,
   output logic [DATA_W-1:0] out_rt_data,
   output logic [DATA_W-1:0] out_imm,
   output logic [25:0]       out_jump,
   output logic [31:0]       out_pc
);

   // Register file storage and its next-state image
   logic [DATA_W-1:0] rf_q [NREGS];
   logic [DATA_W-1:0] rf_d [NREGS];

   // Output (ID/EX) register
   logic              out_valid_q,   out_valid_d;
   logic [5:0]        out_opcode_q,  out_opcode_d;
   logic [4:0]        out_rs_q,      out_rs_d;
   logic [4:0]        out_rt_q,      out_rt_d;
   logic [4:0]        out_rd_q,      out_rd_d;
   logic [DATA_W-1:0] out_rs_data_q, out_rs_data_d;
   logic [DATA_W-1:0] out_rt_data_q, out_rt_data_d;
   logic [DATA_W-1:0] out_imm_q,     out_imm_d;
   logic [25:0]       out_jump_q,    out_jump_d;
   logic [31:0]       out_pc_q,      out_pc_d;

   // Decoded fields of the incoming instruction
   logic [5:0]        opc;
   logic [4:0]        rs_a;
   logic [4:0]        rt_a;
   logic [15:0]       imm16;
   logic              wb_writable;
   logic [DATA_W-1:0] rs_val;
   logic [DATA_W-1:0] rt_val;
   logic [DATA_W-1:0] imm_ext;
   logic              advance;
   logic              hazard;

   assign opc   = instruction[31:26];
   assign rs_a  = instruction[25:21];
   assign rt_a  = instruction[20:16];
   assign imm16 = instruction[15:0];

   // A write-back is committed only to an existing, non-hardwired register
   always_comb begin
      wb_writable = wb_en
                    & ~(ZERO_REG & (wb_addr == {AW{1'b0}}))
                    & (32'(wb_addr) < 32'(NREGS));
   end

   // Register-file next state: the single write port updates one entry
   always_comb begin
      for (int i = 0; i < NREGS; i++) begin
         rf_d[i] = (wb_writable && (wb_addr == AW'(i))) ? wb_data : rf_q[i];
      end
   end

   // Combinational operand reads with same-cycle write-back bypass
   always_comb begin
      rs_val = {DATA_W{1'b0}};
      rt_val = {DATA_W{1'b0}};
      if (ZERO_REG && (rs_a == 5'd0)) begin
         rs_val = {DATA_W{1'b0}};
      end else if (wb_writable && (32'(wb_addr) == 32'(rs_a))) begin
         rs_val = wb_data;
      end else if (32'(rs_a) < 32'(NREGS)) begin
         rs_val = rf_q[rs_a[AW-1:0]];
      end else begin
         rs_val = {DATA_W{1'b0}};
      end
      if (ZERO_REG && (rt_a == 5'd0)) begin
         rt_val = {DATA_W{1'b0}};
      end else if (wb_writable && (32'(wb_addr) == 32'(rt_a))) begin
         rt_val = wb_data;
      end else if (32'(rt_a) < 32'(NREGS)) begin
         rt_val = rf_q[rt_a[AW-1:0]];
      end else begin
         rt_val = {DATA_W{1'b0}};
      end
   end

   // Immediate extension: logical ops zero-extend, LUI shifts up, rest sign-extend
   always_comb begin
      imm_ext = {DATA_W{1'b0}};
      case (opc)
         6'h0C, 6'h0D, 6'h0E: imm_ext = DATA_W'(imm16);
         6'h0F:               imm_ext = DATA_W'({imm16, 16'h0000});
         default:             imm_ext = DATA_W'($signed(imm16));
      endcase
   end

   // Handshake: advance when the output slot is free or being drained;
   // hold off a consumer of a load still sitting in the output slot
   always_comb begin
      advance  = ~out_valid_q | out_ready;
      hazard   = out_valid_q & (out_opcode_q == LOAD_OPC) & (out_rt_q != 5'd0)
                 & ((out_rt_q == rs_a) | (out_rt_q == rt_a));
      in_ready = rst & (flush | (advance & ~hazard));
   end

   // Output-register next state in priority: flush, bubble, load, drain, stall
   always_comb begin
      out_valid_d   = out_valid_q;
      out_opcode_d  = out_opcode_q;
      out_rs_d      = out_rs_q;
      out_rt_d      = out_rt_q;
      out_rd_d      = out_rd_q;
      out_rs_data_d = out_rs_data_q;
      out_rt_data_d = out_rt_data_q;
      out_imm_d     = out_imm_q;
      out_jump_d    = out_jump_q;
      out_pc_d      = out_pc_q;
      if (flush) begin
         out_valid_d = 1'b0;
      end else if (advance && hazard) begin
         out_valid_d = 1'b0;
      end else if (advance && in_valid) begin
         out_valid_d   = 1'b1;
         out_opcode_d  = opc;
         out_rs_d      = rs_a;
         out_rt_d      = rt_a;
         out_rd_d      = instruction[15:11];
         out_rs_data_d = rs_val;
         out_rt_data_d = rt_val;
         out_imm_d     = imm_ext;
         out_jump_d    = instruction[25:0];
         out_pc_d      = pc_in;
      end else if (advance) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end
   end

   // Register-file state with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NREGS; i++) begin
            rf_q[i] <= {DATA_W{1'b0}};
         end
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            rf_q[i] <= rf_d[i];
         end
      end
   end

   // ID/EX output register with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         out_valid_q   <= 1'b0;
         out_opcode_q  <= 6'd0;
         out_rs_q      <= 5'd0;
         out_rt_q      <= 5'd0;
         out_rd_q      <= 5'd0;
         out_rs_data_q <= {DATA_W{1'b0}};
         out_rt_data_q <= {DATA_W{1'b0}};
         out_imm_q     <= {DATA_W{1'b0}};
         out_jump_q    <= 26'd0;
         out_pc_q      <= 32'd0;
      end else begin
         out_valid_q   <= out_valid_d;
         out_opcode_q  <= out_opcode_d;
         out_rs_q      <= out_rs_d;
         out_rt_q      <= out_rt_d;
         out_rd_q      <= out_rd_d;
         out_rs_data_q <= out_rs_data_d;
         out_rt_data_q <= out_rt_data_d;
         out_imm_q     <= out_imm_d;
         out_jump_q    <= out_jump_d;
         out_pc_q      <= out_pc_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_opcode  = out_opcode_q;
   assign out_rs      = out_rs_q;
   assign out_rt      = out_rt_q;
   assign out_rd      = out_rd_q;
   assign out_rs_data = out_rs_data_q;
   assign out_rt_data = out_rt_data_q;
   assign out_imm     = out_imm_q;
   assign out_jump    = out_jump_q;
   assign out_pc      = out_pc_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Scoreboard bench for id_stage_pipe: a behavioural model predicts accepted
// bundles and in_ready; a separate monitor compares bundles at handshake.
module tb_id_stage_pipe;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, flush, wb_en, out_valid, out_ready;
   logic [31:0] instruction, pc_in, wb_data;
   logic [4:0]  wb_addr;
   logic [5:0]  out_opcode;
   logic [4:0]  out_rs, out_rt, out_rd;
   logic [31:0] out_rs_data, out_rt_data, out_imm, out_pc;
   logic [25:0] out_jump;

   typedef struct packed {
      logic [5:0]  opcode;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [31:0] rs_data;
      logic [31:0] rt_data;
      logic [31:0] imm;
      logic [25:0] jump;
      logic [31:0] pc;
   } bundle_t;

   bundle_t     exp_q[$];
   int          total = 0;
   int          bad   = 0;

   // Reference state
   logic [31:0] mregs [32];
   logic        m_valid = 1'b0;
   logic [5:0]  m_op    = 6'd0;
   logic [4:0]  m_rt    = 5'd0;
   logic        m_known = 1'b0;
   logic        m_after_rst = 1'b0;

   always #5 clk = ~clk;

   id_stage_pipe dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .instruction(instruction), .pc_in(pc_in), .flush(flush),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
      .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
      .out_rs_data(out_rs_data), .out_rt_data(out_rt_data), .out_imm(out_imm),
      .out_jump(out_jump), .out_pc(out_pc)
   );

   task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ext_imm(input logic [5:0] op, input logic [15:0] imm);
      int unsigned v;
      v = 32'(imm);
      if (op == 6'h0C || op == 6'h0D || op == 6'h0E) return v;
      else if (op == 6'h0F) return v * 32'd65536;
      else if (v >= 32'd32768) return v + 32'hFFFF0000;
      else return v;
   endfunction

   function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   // One clock cycle: drive, predict, check in_ready/out_valid, advance model
   task automatic cyc(input logic r, input logic iv, input logic [31:0] ins,
                      input logic [31:0] pc, input logic fl, input logic we,
                      input logic [4:0] wa, input logic [31:0] wd, input logic ordy);
      logic    haz, adv, exp_rdy, next_after;
      logic [4:0] rs_i, rt_i;
      bundle_t b;
      rst = r; in_valid = iv; instruction = ins; pc_in = pc; flush = fl;
      wb_en = we; wb_addr = wa; wb_data = wd; out_ready = ordy;
      #1;
      rs_i    = ins[25:21];
      rt_i    = ins[20:16];
      haz     = m_valid && (m_op == 6'h23) && (m_rt != 5'd0) && (m_rt == rs_i || m_rt == rt_i);
      adv     = !m_valid || ordy;
      exp_rdy = r && (fl || (adv && !haz));
      check("in_ready", 200'(in_ready), 200'(exp_rdy));
      if (m_known) check("out_valid", 200'(out_valid), 200'(m_valid));
      if (m_after_rst)
         check("reset_fields", 200'({out_opcode, out_rs, out_rt, out_rd, out_rs_data,
                                     out_rt_data, out_imm, out_jump, out_pc}), 200'(0));
      next_after = 1'b0;
      if (!r) begin
         for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
         m_valid = 1'b0; m_op = 6'd0; m_rt = 5'd0;
         exp_q.delete();
         next_after = 1'b1;
      end else begin
         if (we && wa != 5'd0) mregs[wa] = wd;
         if (fl) begin
            exp_q.delete();
            m_valid = 1'b0;
         end else if (adv && haz) begin
            m_valid = 1'b0;
         end else if (adv && iv) begin
            b.opcode  = ins[31:26];
            b.rs      = rs_i;
            b.rt      = rt_i;
            b.rd      = ins[15:11];
            b.rs_data = mregs[rs_i];
            b.rt_data = mregs[rt_i];
            b.imm     = ext_imm(ins[31:26], ins[15:0]);
            b.jump    = ins[25:0];
            b.pc      = pc;
            exp_q.push_back(b);
            m_valid = 1'b1; m_op = ins[31:26]; m_rt = rt_i;
         end else if (adv) begin
            m_valid = 1'b0;
         end
      end
      @(posedge clk);
      m_known     = 1'b1;
      m_after_rst = next_after;
      @(negedge clk);
   endtask

   // Monitor: compare the presented bundle whenever EX takes it
   initial begin
      bundle_t e;
      forever begin
         @(negedge clk);
         #2;
         if (rst === 1'b1 && flush === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_bundle: got pc %h expected none", out_pc);
            end else begin
               e = exp_q.pop_front();
               check("bundle", 200'({out_opcode, out_rs, out_rt, out_rd, out_rs_data,
                                     out_rt_data, out_imm, out_jump, out_pc}), 200'(e));
            end
         end
      end
   end

   // Stimulus: directed scenarios followed by randomized traffic
   initial begin
      logic [5:0]  ops [8];
      logic        r, fl, ordy;
      logic [31:0] ins;
      ops[0] = 6'h00; ops[1] = 6'h08; ops[2] = 6'h0C; ops[3] = 6'h0D;
      ops[4] = 6'h0E; ops[5] = 6'h0F; ops[6] = 6'h23; ops[7] = 6'h2B;
      rst = 1'b0; in_valid = 1'b0; instruction = 32'd0; pc_in = 32'd0; flush = 1'b0;
      wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'd0; out_ready = 1'b0;
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
      @(negedge clk);

      // Reset then idle
      cyc(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
      cyc(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
      cyc(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
      // Read r1..r31 after reset
      for (int i = 1; i < 32; i++)
         cyc(1'b1, 1'b1, mk(6'h00, 5'(i), 5'(i), 16'h0000), 32'(i * 4), 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
      cyc(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);

      // Bypass and r0 write
      cyc(1'b1, 1'b1, mk(6'h00, 5'd5, 5'd0, 16'h2820), 32'h100, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1);
      cyc(1'b1, 1'b1, mk(6'h00, 5'd0, 5'd5, 16'h0000), 32'h104, 1'b0, 1'b1, 5'd0, 32'h00001234, 1'b1);
      cyc(1'b1, 1'b1, mk(6'h00, 5'd0, 5'd0, 16'h0000), 32'h108, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);

      // Immediates for 0x8001
      cyc(1'b1, 1'b1, mk(6'h08, 5'd1, 5'd2, 16'h8001), 32'h200, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
      cyc(1'b1, 1'b1, mk(6'h0D, 5'd1, 5'd2, 16'h8001), 32'h204, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
      cyc(1'b1, 1'b1, mk(6'h0F, 5'd1, 5'd2, 16'h8001), 32'h208, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
      cyc(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);

      // Load-use bubble, then a non-dependent follower
      cyc(1'b1, 1'b1, mk(6'h23, 5'd1, 5'd7, 16'h0004), 32'h300, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
      cyc(1'b1, 1'b1, mk(6'h00, 5'd7, 5'd2, 16'h1820), 32'h304, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
      cyc(1'b1, 1'b1, mk(6'h00, 5'd7, 5'd2, 16'h1820), 32'h304, 1'b0, 1'b1, 5'd7, 32'h0BADF00D, 1'b1);
      cyc(1'b1, 1'b1, mk(6'h23, 5'd1, 5'd7, 16'h0004), 32'h308, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
      cyc(1'b1, 1'b1, mk(6'h00, 5'd8, 5'd2, 16'h1820), 32'h30C, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
      cyc(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);

      // Backpressure with write-back still landing
      cyc(1'b1, 1'b1, mk(6'h00, 5'd3, 5'd4, 16'h0000), 32'h400, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
      for (int i = 0; i < 3; i++)
         cyc(1'b1, 1'b1, mk(6'h00, 5'd9, 5'd10, 16'h0000), 32'h404, 1'b0, 1'b1, 5'(9 + i), 32'hA000 + 32'(i), 1'b0);
      cyc(1'b1, 1'b1, mk(6'h00, 5'd9, 5'd10, 16'h0000), 32'h404, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
      cyc(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);

      // Flush kills slot and offered instruction; flush under reset
      cyc(1'b1, 1'b1, mk(6'h00, 5'd9, 5'd9, 16'h0000), 32'h500, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
      cyc(1'b1, 1'b1, mk(6'h00, 5'd10, 5'd9, 16'h0000), 32'h504, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
      cyc(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
      cyc(1'b1, 1'b1, mk(6'h00, 5'd9, 5'd9, 16'h0000), 32'h508, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
      cyc(1'b0, 1'b1, mk(6'h00, 5'd9, 5'd9, 16'h0000), 32'h50C, 1'b1, 1'b1, 5'd9, 32'h55, 1'b1);
      cyc(1'b1, 1'b1, mk(6'h00, 5'd9, 5'd10, 16'h0000), 32'h510, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
      cyc(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);

      // Randomized traffic
      for (int n = 0; n < 2000; n++) begin
         r    = ($urandom_range(0, 99) != 0);
         fl   = ($urandom_range(0, 99) < 4);
         ordy = fl ? 1'b0 : ($urandom_range(0, 9) < 7);
         ins  = {ops[$urandom_range(0, 7)], 5'($urandom_range(0, 9)),
                 5'($urandom_range(0, 9)), 16'($urandom)};
         cyc(r, ($urandom_range(0, 9) < 8), ins, $urandom, fl,
             1'($urandom), 5'($urandom_range(0, 9)), $urandom, ordy);
      end

      // Drain and confirm nothing expected is left over
      for (int i = 0; i < 3; i++)
         cyc(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
      check("drain_empty", 200'(exp_q.size()), 200'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
